id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode stage plus ID/EX pipeline register; consumes instruction_D/current_pc_D from the fetch stage.
//  Decodes the RV32I subset, reads the 32x32 register file, generates immediates and drives EX controls.
//  Owns load-use hazard detection: drives PCWrite/IF_ID_Write back to fetch and inserts bubbles.
//  The register-file write port is driven from WB.
// PARAMETERS
//  PC_BITS    10  width of PC carried down the pipe
//  XLEN       32  datapath/register width
//  NUM_REGS   32  architectural registers; x0 hard-wired to zero
// PORTS
//  clk            in   1        single clock, rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  instruction_D  in   32       instruction from IF/ID
//  current_pc_D   in   PC_BITS  PC of instruction_D
//  flush_E        in   1        branch/jump taken in EX (PCSrc); discard ID contents
//  wb_RegWrite    in   1        WB write enable
//  wb_rd          in   5        WB destination register
//  wb_data        in   XLEN     WB write data
//  PCWrite        out  1        to fetch: 0 holds PC
//  IF_ID_Write    out  1        to fetch: 0 holds IF/ID
//  RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, Branch_E, BranchNe_E, Jump_E, ALUSrc_E  out  1 each  EX controls
//  ALUOp_E        out  4        ALU operation code (package enum)
//  rs1_data_E, rs2_data_E  out  XLEN  register operands
//  imm_E          out  XLEN     sign-extended immediate
//  rs1_E, rs2_E, rd_E  out  5   register indices, used for forwarding
//  pc_E           out  PC_BITS  PC of the EX instruction
// BEHAVIOUR
//  - Reset (reset_n=0, async): all *_E outputs are 0; this is a NOP bubble. PCWrite=IF_ID_Write=1.
//  - Supported opcodes: R-type (add,sub,and,or,xor,sll,srl,sra,slt), I-ALU, LW, SW, BEQ, BNE, JAL, LUI.
//  - Immediates: I/S/B/J/U formats are sign-extended to XLEN. B and J immediates carry LSB=0.
//  - Unknown opcode: all controls are 0 (bubble). Indices and data are still latched.
//  - Load-use hazard (combinational): MemRead_E && rd_E!=0 && (rd_E==rs1 || rd_E==rs2 of the ID instr).
//    The rs2 comparison applies only to formats that use rs2 (R, S, B).
//    When a hazard is detected: PCWrite=0, IF_ID_Write=0, and a bubble is clocked into ID/EX. This stalls for exactly 1 cycle.
//  - Register priority at each clock edge: reset > flush_E (bubble) > hazard (bubble) > normal load.
//  - When flush_E=1, PCWrite and IF_ID_Write are forced to 1, even if a hazard is detected.
//  - A bubble zeroes every control bit. Data, index and PC fields are don't-care and are zeroed here.
//  - Latency: 1 clock from instruction_D valid to *_E outputs.
//  - Register file: 2 async read ports and 1 sync write port on the clk rising edge.
//    Writes are ignored when wb_rd==0. Reads of x0 return 0. Contents are not reset.
//  - Reset mid-stall: the outputs and registers take their reset values immediately.
//    The stall releases because rd_E/MemRead_E are cleared.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    if wb_RegWrite && wb_rd!=0 && wb_rd==rsN in the same cycle, the read port returns wb_data (write-first).
//  RF_BYPASS_EN undefined:
//    the read port returns the old register value (read-first).
//    Software must separate a WB write from a dependent ID read by at least 1 instruction.
// STRUCTURE
//  - Package riscv_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI).
//  - riscv_pkg also holds the ALUOp enum (ALU_ADD..ALU_SLT, ALU_PASSB) and the funct3/funct7 constants.
//  - Sub-module reg_file (NUM_REGS x XLEN, 2R1W, RF_BYPASS_EN honoured inside).
//  - Decoder, imm-gen, hazard unit and ID/EX register are kept inline.
// TESTING
//  1. Reset: hold reset_n=0 with a non-zero instruction -> all *_E=0, PCWrite=1, IF_ID_Write=1.
//  2. addi x5,x0,-3 (0xFFD00293) at PC 0x010 -> next cycle:
//     RegWrite_E=1, ALUSrc_E=1, imm_E=0xFFFFFFFD, rd_E=5, pc_E=0x010.
//  3. lw x6,0(x1), then add x7,x6,x2 -> in the cycle lw is in EX: PCWrite=0, IF_ID_Write=0.
//     Next cycle: bubble (all controls 0). The cycle after: add in EX with rs1_E=6.
//  4. flush_E=1 while beq is in ID and a load-use hazard is present -> next cycle bubble.
//     PCWrite=1 and IF_ID_Write=1 during flush.
//  5. WB writes x9=0xDEADBEEF while ID reads x9 -> rs1_data_E=0xDEADBEEF if RF_BYPASS_EN, else the old value.
//     Also: a write to x0 -> reading x0 yields 0.
//  6. Immediates: jal x1,+2048 -> imm_E=0x00000800, Jump_E=1. sw x3,-4(x2) -> imm_E=0xFFFFFFFC, MemWrite_E=1.
//     Opcode 0x7F -> all controls 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I subset opcodes, funct fields, ALU op encoding and control bundle
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // alt is funct7[5]; callers mask it for I-type where only srai uses it
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      F3_AND:     return ALU_AND;
      default:    return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX register outputs handed to the EX stage
interface id_ex_stage_if
  import riscv_pkg::*;
#(
  parameter int PC_BITS = 10,
  parameter int XLEN    = 32
);
  logic               RegWrite_E;
  logic               MemRead_E;
  logic               MemWrite_E;
  logic               MemToReg_E;
  logic               Branch_E;
  logic               BranchNe_E;
  logic               Jump_E;
  logic               ALUSrc_E;
  alu_op_e            ALUOp_E;
  logic [XLEN-1:0]    rs1_data_E;
  logic [XLEN-1:0]    rs2_data_E;
  logic [XLEN-1:0]    imm_E;
  logic [4:0]         rs1_E;
  logic [4:0]         rs2_E;
  logic [4:0]         rd_E;
  logic [PC_BITS-1:0] pc_E;

  modport master (
    output RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, Branch_E, BranchNe_E,
           Jump_E, ALUSrc_E, ALUOp_E, rs1_data_E, rs2_data_E, imm_E, rs1_E, rs2_E,
           rd_E, pc_E
  );

  modport slave (
    input RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E, Branch_E, BranchNe_E,
          Jump_E, ALUSrc_E, ALUOp_E, rs1_data_E, rs2_data_E, imm_E, rs1_E, rs2_E,
          rd_E, pc_E
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file, x0 reads zero; RF_BYPASS_EN makes reads write-first
module reg_file #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);
  logic [XLEN-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (we_i && waddr_i != 5'd0) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? '0 : mem_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? '0 : mem_q[raddr2_i];
`ifdef RF_BYPASS_EN
    if (we_i && waddr_i != 5'd0 && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i != 5'd0 && waddr_i == raddr2_i) rdata2_o = wdata_i;
`endif
  end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode, immediate gen, load-use stall and ID/EX register
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int PC_BITS  = 10,
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction_D,
  input  logic [PC_BITS-1:0] current_pc_D,
  input  logic               flush_E,
  input  logic               wb_RegWrite,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  id_ex_stage_if.master      ex
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [31:0]     imm_i, imm_s, imm_b, imm_j, imm_u, imm32;
  ctrl_t           ctrl_dec;
  logic            uses_rs2, hazard;

  ctrl_t              ctrl_q, ctrl_d;
  logic [XLEN-1:0]    rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [PC_BITS-1:0] pc_q, pc_d;

  assign opcode = instruction_D[6:0];
  assign funct3 = instruction_D[14:12];
  assign rs1    = instruction_D[19:15];
  assign rs2    = instruction_D[24:20];
  assign rd     = instruction_D[11:7];

  assign imm_i = {{20{instruction_D[31]}}, instruction_D[31:20]};
  assign imm_s = {{20{instruction_D[31]}}, instruction_D[31:25], instruction_D[11:7]};
  assign imm_b = {{19{instruction_D[31]}}, instruction_D[31], instruction_D[7],
                  instruction_D[30:25], instruction_D[11:8], 1'b0};
  assign imm_j = {{11{instruction_D[31]}}, instruction_D[31], instruction_D[19:12],
                  instruction_D[20], instruction_D[30:21], 1'b0};
  assign imm_u = {instruction_D[31:12], 12'b0};

  reg_file #(.NUM_REGS(NUM_REGS), .XLEN(XLEN)) u_reg_file (
    .clk      (clk),
    .we_i     (wb_RegWrite),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_comb begin
    ctrl_d_default: begin end
    ctrl_dec = '0;
    imm32    = '0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = alu_op_decode(funct3, instruction_D[30]);
        uses_rs2           = 1'b1;
      end
      OP_IMM: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        // bit 30 is immediate data except on the shift-right encoding
        ctrl_dec.alu_op    = alu_op_decode(funct3, (funct3 == F3_SRL_SRA) && instruction_D[30]);
        imm32              = imm_i;
      end
      OP_LOAD: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.alu_op     = ALU_ADD;
        imm32               = imm_i;
      end
      OP_STORE: begin
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
        imm32              = imm_s;
        uses_rs2           = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_dec.branch    = (funct3 == F3_BEQ);
        ctrl_dec.branch_ne = (funct3 == F3_BNE);
        ctrl_dec.alu_op    = ALU_SUB;
        imm32              = imm_b;
        uses_rs2           = 1'b1;
      end
      OP_JAL: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
        imm32              = imm_j;
      end
      OP_LUI: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.alu_op    = ALU_PASSB;
        imm32              = imm_u;
      end
      default: ;
    endcase
  end

  assign hazard = ctrl_q.mem_read && (rd_q != 5'd0) &&
                  ((rd_q == rs1) || (uses_rs2 && (rd_q == rs2)));

  // a taken branch squashes the ID instruction, so stalling it would be pointless
  assign PCWrite     = flush_E || !hazard;
  assign IF_ID_Write = flush_E || !hazard;

  always_comb begin
    ctrl_d     = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    pc_d       = '0;
    if (!flush_E && !hazard) begin
      ctrl_d     = ctrl_dec;
      rs1_data_d = rs1_data;
      rs2_data_d = rs2_data;
      imm_d      = XLEN'($signed(imm32));
      rs1_d      = rs1;
      rs2_d      = rs2;
      rd_d       = rd;
      pc_d       = current_pc_D;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
    end
  end

  assign ex.RegWrite_E = ctrl_q.reg_write;
  assign ex.MemRead_E  = ctrl_q.mem_read;
  assign ex.MemWrite_E = ctrl_q.mem_write;
  assign ex.MemToReg_E = ctrl_q.mem_to_reg;
  assign ex.Branch_E   = ctrl_q.branch;
  assign ex.BranchNe_E = ctrl_q.branch_ne;
  assign ex.Jump_E     = ctrl_q.jump;
  assign ex.ALUSrc_E   = ctrl_q.alu_src;
  assign ex.ALUOp_E    = ctrl_q.alu_op;
  assign ex.rs1_data_E = rs1_data_q;
  assign ex.rs2_data_E = rs2_data_q;
  assign ex.imm_E      = imm_q;
  assign ex.rs1_E      = rs1_q;
  assign ex.rs2_E      = rs2_q;
  assign ex.rd_E       = rd_q;
  assign ex.pc_E       = pc_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against an instruction-level model
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int PC_BITS = 10;
  localparam int XLEN    = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [31:0]        instruction_D;
  logic [PC_BITS-1:0] current_pc_D;
  logic               flush_E;
  logic               wb_RegWrite;
  logic [4:0]         wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               PCWrite;
  logic               IF_ID_Write;

  id_ex_stage_if #(.PC_BITS(PC_BITS), .XLEN(XLEN)) ex_if ();

  id_ex_stage #(.PC_BITS(PC_BITS), .XLEN(XLEN), .NUM_REGS(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instruction_D (instruction_D),
    .current_pc_D  (current_pc_D),
    .flush_E       (flush_E),
    .wb_RegWrite   (wb_RegWrite),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .ex            (ex_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rw, mr, mw, m2r, br, bne, j, src;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  pc;
  } exp_t;

  exp_t        m_e;
  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_of(input logic alt, input logic [2:0] f3);
    case ({alt, f3})
      4'b0000: return 4'(ALU_ADD);
      4'b1000: return 4'(ALU_SUB);
      4'b0001: return 4'(ALU_SLL);
      4'b0010: return 4'(ALU_SLT);
      4'b0100: return 4'(ALU_XOR);
      4'b0101: return 4'(ALU_SRL);
      4'b1101: return 4'(ALU_SRA);
      4'b0110: return 4'(ALU_OR);
      4'b0111: return 4'(ALU_AND);
      default: return 4'(ALU_ADD);
    endcase
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return regs[r];
  endfunction

  function automatic exp_t predict(input logic [31:0] ins, input logic [9:0] pc, input logic we,
                                   input logic [4:0] wr, input logic [31:0] wd);
    exp_t        e;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    e     = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.a   = rd_reg(ins[19:15], we, wr, wd);
    e.b   = rd_reg(ins[24:20], we, wr, wd);
    case (ins[6:0])
      7'h33: begin e.rw = 1; e.op = alu_of(ins[30], ins[14:12]); end
      7'h13: begin
        e.rw = 1; e.src = 1;
        e.op = alu_of(ins[14:12] == 3'd5 && ins[30], ins[14:12]);
        i12 = ins[31:20]; e.imm = 32'($signed(i12));
      end
      7'h03: begin
        e.rw = 1; e.mr = 1; e.m2r = 1; e.src = 1; e.op = 4'(ALU_ADD);
        i12 = ins[31:20]; e.imm = 32'($signed(i12));
      end
      7'h23: begin
        e.mw = 1; e.src = 1; e.op = 4'(ALU_ADD);
        i12 = {ins[31:25], ins[11:7]}; e.imm = 32'($signed(i12));
      end
      7'h63: begin
        e.br = (ins[14:12] == 3'd0); e.bne = (ins[14:12] == 3'd1); e.op = 4'(ALU_SUB);
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; e.imm = 32'($signed(b13));
      end
      7'h6F: begin
        e.rw = 1; e.j = 1; e.op = 4'(ALU_ADD);
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; e.imm = 32'($signed(j21));
      end
      7'h37: begin e.rw = 1; e.src = 1; e.op = 4'(ALU_PASSB); e.imm = {ins[31:12], 12'h000}; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {ex_if.RegWrite_E, ex_if.MemRead_E, ex_if.MemWrite_E, ex_if.MemToReg_E,
            ex_if.Branch_E, ex_if.BranchNe_E, ex_if.Jump_E, ex_if.ALUSrc_E, 4'(ex_if.ALUOp_E)};
  endfunction

  task automatic check_e();
    check("ctrl", 64'(dut_ctrl()),
          64'({m_e.rw, m_e.mr, m_e.mw, m_e.m2r, m_e.br, m_e.bne, m_e.j, m_e.src, m_e.op}));
    check("rs1_data", 64'(ex_if.rs1_data_E), 64'(m_e.a));
    check("rs2_data", 64'(ex_if.rs2_data_E), 64'(m_e.b));
    check("imm", 64'(ex_if.imm_E), 64'(m_e.imm));
    check("idx", 64'({ex_if.rs1_E, ex_if.rs2_E, ex_if.rd_E}), 64'({m_e.rs1, m_e.rs2, m_e.rd}));
    check("pc", 64'(ex_if.pc_E), 64'(m_e.pc));
  endtask

  // called in the low clock phase; returns at the next falling edge
  task automatic step(input logic [31:0] ins, input logic [9:0] pc, input logic fl, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd, output logic adv);
    logic hz, r2use;
    exp_t nxt;
    instruction_D = ins; current_pc_D = pc; flush_E = fl;
    wb_RegWrite = we; wb_rd = wr; wb_data = wd;
    #1;
    r2use = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    hz = m_e.mr && (m_e.rd != 5'd0) && ((m_e.rd == ins[19:15]) || (r2use && m_e.rd == ins[24:20]));
    check("pcwrite", 64'(PCWrite), 64'(fl || !hz));
    check("if_id_write", 64'(IF_ID_Write), 64'(fl || !hz));
    nxt = (fl || hz) ? '0 : predict(ins, pc, we, wr, wd);
    @(posedge clk);
    m_e = nxt;
    if (we && wr != 5'd0) regs[wr] = wd;
    @(negedge clk);
    check_e();
    adv = fl || !hz;
  endtask

  function automatic logic [31:0] gen_ins();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    f3  = 3'($urandom);
    if (f3 == 3'd3) f3 = 3'd0;
    case ($urandom_range(0, 8))
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      1: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'h13};
      end
      2, 8: return {imm, rs1, 3'b010, rd, 7'h03};
      3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      4: return {imm[11:5], rs2, rs1, 2'b00, 1'($urandom_range(0, 1)), imm[4:0], 7'h63};
      5: return {20'($urandom), rd, 7'h6F};
      6: return {20'($urandom), rd, 7'h37};
      default: return {25'($urandom), 7'h7F};
    endcase
  endfunction

  localparam logic [31:0] LW_X6  = 32'h0000A303;
  localparam logic [31:0] ADD_X7 = 32'h002303B3;
  localparam logic [31:0] BEQ_X6 = 32'h00230063;

  initial begin
    logic        adv, fl, we;
    logic [4:0]  wr;
    logic [31:0] cur, old9;
    logic [9:0]  pc;

    reset_n = 1'b0; instruction_D = 32'hFFD00293; current_pc_D = 10'h3FF;
    flush_E = 1'b0; wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
    m_e = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_e();
    check("rst_pcwrite", 64'(PCWrite), 64'(1));
    check("rst_if_id_write", 64'(IF_ID_Write), 64'(1));
    reset_n = 1'b1;

    for (int i = 1; i < 32; i++) step(32'h0, 10'h0, 1'b0, 1'b1, 5'(i), $urandom, adv);

    step(32'hFFD00293, 10'h010, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("addi_ctrl", 64'({ex_if.RegWrite_E, ex_if.ALUSrc_E}), 64'(2'b11));
    check("addi_imm", 64'(ex_if.imm_E), 64'(32'hFFFFFFFD));
    check("addi_rd", 64'(ex_if.rd_E), 64'(5));
    check("addi_pc", 64'(ex_if.pc_E), 64'(10'h010));

    step(LW_X6, 10'h014, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    instruction_D = ADD_X7; #1;
    check("lu_pcwrite", 64'(PCWrite), 64'(0));
    check("lu_if_id_write", 64'(IF_ID_Write), 64'(0));
    step(ADD_X7, 10'h018, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("lu_bubble", 64'(dut_ctrl()), 64'(0));
    step(ADD_X7, 10'h018, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("lu_add_rs1", 64'(ex_if.rs1_E), 64'(6));
    check("lu_add_regwrite", 64'(ex_if.RegWrite_E), 64'(1));

    step(LW_X6, 10'h01C, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    instruction_D = BEQ_X6; flush_E = 1'b1; #1;
    check("fl_pcwrite", 64'(PCWrite), 64'(1));
    check("fl_if_id_write", 64'(IF_ID_Write), 64'(1));
    step(BEQ_X6, 10'h020, 1'b1, 1'b0, 5'd0, 32'd0, adv);
    check("fl_bubble", 64'(dut_ctrl()), 64'(0));

    old9 = regs[9];
    step(32'h00048513, 10'h024, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF, adv);
`ifdef RF_BYPASS_EN
    check("wb_same_cycle", 64'(ex_if.rs1_data_E), 64'(32'hDEADBEEF));
`else
    check("wb_same_cycle", 64'(ex_if.rs1_data_E), 64'(old9));
`endif
    step(32'h00048513, 10'h028, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("wb_next_cycle", 64'(ex_if.rs1_data_E), 64'(32'hDEADBEEF));
    step(32'h0, 10'h02C, 1'b0, 1'b1, 5'd0, 32'h12345678, adv);
    step(32'h00000593, 10'h030, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("x0_read", 64'(ex_if.rs1_data_E), 64'(0));

    step(32'h001000EF, 10'h034, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("jal_imm", 64'(ex_if.imm_E), 64'(32'h00000800));
    check("jal_jump", 64'(ex_if.Jump_E), 64'(1));
    step(32'hFE312E23, 10'h038, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("sw_imm", 64'(ex_if.imm_E), 64'(32'hFFFFFFFC));
    check("sw_memwrite", 64'(ex_if.MemWrite_E), 64'(1));
    step(32'h0000007F, 10'h03C, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("unknown_ctrl", 64'(dut_ctrl()), 64'(0));

    step(LW_X6, 10'h040, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    instruction_D = ADD_X7; #1;
    check("ms_stalled", 64'(PCWrite), 64'(0));
    reset_n = 1'b0; #1;
    check("ms_pcwrite", 64'(PCWrite), 64'(1));
    check("ms_memread", 64'(ex_if.MemRead_E), 64'(0));
    check("ms_rd", 64'(ex_if.rd_E), 64'(0));
    m_e = '0;
    reset_n = 1'b1;
    step(ADD_X7, 10'h044, 1'b0, 1'b0, 5'd0, 32'd0, adv);
    check("ms_add_loaded", 64'(ex_if.rs1_E), 64'(6));

    pc = 10'h100; adv = 1'b1; cur = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (adv) begin cur = gen_ins(); pc = pc + 10'd4; end
      fl = ($urandom_range(0, 7) == 0);
      we = 1'($urandom_range(0, 1));
      wr = 5'($urandom_range(0, 7));
      step(cur, pc, fl, we, wr, $urandom, adv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
